// File: rtl/fnn_pkg.sv
// Shared types and constants for the neuron weight-memory write path.
// Holds the loader state encoding and the default weight word width.
package fnn_pkg;

  localparam int FNN_DATA_WIDTH = 16;

  typedef logic [FNN_DATA_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } wl_state_e;

endpackage

// File: rtl/wl_checksum_acc.sv
// Clearable modulo-2^DATA_WIDTH accumulator used to check the trailing
// checksum word of a weight packet. Only present in checksum builds.
module wl_checksum_acc
  import fnn_pkg::*;
#(
  parameter int DATA_WIDTH = FNN_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_add,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_sum
);

  logic [DATA_WIDTH-1:0] r_sum;

  // Running sum wraps naturally; clear has priority over add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/weight_loader.sv
// Streams NUM_WEIGHT words into one selected neuron weight memory via a
// one-hot write-enable bus, with a one-cycle registered write port.
// Optional trailing checksum word: define WEIGHT_LOAD_CHECKSUM_EN.
module weight_loader
  import fnn_pkg::*;
#(
  parameter int NUM_WEIGHT = 30,
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = FNN_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter int SEL_WIDTH  = $clog2(NUM_NEURON)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  neuron_sel,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [NUM_NEURON-1:0] wen,
  output logic [ADDR_WIDTH-1:0] wadd,
  output logic [DATA_WIDTH-1:0] win,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [SEL_WIDTH:0]    NN_LIM   = (SEL_WIDTH + 1)'(NUM_NEURON);

  wl_state_e             r_state;
  wl_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [SEL_WIDTH-1:0]  w_sel_nxt;
  logic                  r_err_flag;
  logic                  w_err_flag_nxt;
  logic                  r_bad_sel;
  logic                  w_bad_sel_nxt;
  logic                  w_wr;
  logic                  w_sel_ok;
  logic [NUM_NEURON-1:0] w_onehot;
  logic [NUM_NEURON-1:0] r_wen;
  logic [ADDR_WIDTH-1:0] r_wadd;
  logic [DATA_WIDTH-1:0] r_win;

  assign w_sel_ok = ({1'b0, neuron_sel} < NN_LIM);

  // Decode the latched neuron select into the write-enable pattern.
  for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_onehot
    assign w_onehot[gi] = (r_sel == SEL_WIDTH'(gi));
  end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic                  w_acc_clr;
  logic [DATA_WIDTH-1:0] w_sum;

  // Sum restarts with each accepted start and tracks every written word.
  assign w_acc_clr = (r_state == ST_IDLE) & start & w_sel_ok;

  wl_checksum_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cks (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_acc_clr),
    .i_add  (w_wr),
    .i_data (s_data),
    .o_sum  (w_sum)
  );
`endif

  // State, counter, select and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_err_flag <= 1'b0;
      r_bad_sel  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_bad_sel  <= w_bad_sel_nxt;
    end
  end

  // Next-state logic, stream handshake and write strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_err_flag_nxt = r_err_flag;
    w_bad_sel_nxt  = 1'b0;
    w_wr           = 1'b0;
    s_ready        = 1'b0;
    done           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_sel_ok) begin
            w_sel_nxt      = neuron_sel;
            w_cnt_nxt      = '0;
            w_err_flag_nxt = 1'b0;
            w_state_nxt    = ST_LOAD;
          end else begin
            w_bad_sel_nxt  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_wr = 1'b1;
          if (r_cnt == LAST_IDX) begin
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            // End-of-packet belongs on the checksum word, not here.
            if (s_last) begin
              w_err_flag_nxt = 1'b1;
              w_state_nxt    = ST_DONE;
            end else begin
              w_state_nxt    = ST_CHK;
            end
`else
            if (!s_last) begin
              w_err_flag_nxt = 1'b1;
            end
            w_state_nxt = ST_DONE;
`endif
          end else if (s_last) begin
            // Short packet: remaining addresses keep old contents.
            w_err_flag_nxt = 1'b1;
            w_state_nxt    = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      ST_CHK: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if ((s_data != w_sum) || !s_last) begin
            w_err_flag_nxt = 1'b1;
          end
          w_state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done           = 1'b1;
        w_err_flag_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered write port: enable for one cycle, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen  <= '0;
      r_wadd <= '0;
      r_win  <= '0;
    end else begin
      r_wen <= w_wr ? w_onehot : '0;
      if (w_wr) begin
        r_wadd <= r_cnt;
        r_win  <= s_data;
      end
    end
  end

  assign wen  = r_wen;
  assign wadd = r_wadd;
  assign win  = r_win;
  assign busy = (r_state != ST_IDLE);
  assign err  = r_bad_sel | ((r_state == ST_DONE) & r_err_flag);

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected writes are queued as words
// are handed over and popped as the write port shows them.
// Checksum cases run when WEIGHT_LOAD_CHECKSUM_EN is defined.
module tb_weight_loader;

  localparam int NW = 30;
  localparam int NN = 30;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  typedef struct {
    logic [NN-1:0] wen;
    logic [4:0]    addr;
    logic [15:0]   data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  neuron_sel = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [NN-1:0] wen;
  logic [4:0]  wadd;
  logic [15:0] win;
  logic        busy;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int wr_addr = 0;
  wr_t exp_q[$];
  logic [15:0] exp_mem [NN][NW];
  logic [15:0] obs_mem [NN][NW];

  always #5 clk = ~clk;

  weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .neuron_sel (neuron_sel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .wen        (wen),
    .wadd       (wadd),
    .win        (win),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Write-port monitor: every enable must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wen !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexp_wr", 64'(wen), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wen", 64'(wen), 64'(e.wen));
        chk("wadd", 64'(wadd), 64'(e.addr));
        chk("win", 64'(win), 64'(e.data));
      end
      for (int j = 0; j < NN; j++) begin
        if (wen[j] === 1'b1 && wadd < 5'(NW)) obs_mem[j][wadd] = win;
      end
    end
  end

  task automatic start_load(input int sel);
    @(posedge clk); #1;
    start = 1'b1;
    neuron_sel = 5'(sel);
    wr_addr = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [15:0] d, input bit lst,
                           input bit gap, input bit push);
    bit ok;
    wr_t e;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = lst;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      return;
    end
    if (push) begin
      e.wen  = NN'(1) << sel;
      e.addr = 5'(wr_addr);
      e.data = d;
      exp_q.push_back(e);
      exp_mem[sel][wr_addr] = d;
      wr_addr++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit exp_err, input bit post);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done === 1'b1) break;
    end
    chk("done_latency", 64'(k), 64'd0);
    chk("err_at_done", 64'(err), 64'(exp_err));
    chk("busy_at_done", 64'(busy), 64'd1);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (post) begin
      @(negedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("err_one_cycle", 64'(err), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic send_packet(input int sel, input logic [15:0] base, input logic [15:0] step,
                             input int n, input bit last_ok, input bit gaps,
                             input bit cks_bad, input int busy_at, input bit post);
    logic [15:0] sum;
    logic [15:0] d;
    bit lst;
    bit exp_err;
    sum = '0;
    start_load(sel);
    for (int i = 0; i < n; i++) begin
      if (i == busy_at) begin
        s_valid = 1'b0;
        start = 1'b1;
        neuron_sel = 5'(sel + 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
      d = base + 16'(i) * step;
      sum = sum + d;
      lst = (i == n - 1) && ((n < NW) ? 1'b1 : (CKS ? 1'b0 : last_ok));
      send_word(sel, d, lst, gaps && (i > 0), 1'b1);
    end
    if (CKS && n == NW) send_word(sel, sum + 16'(cks_bad), last_ok, 1'b0, 1'b0);
    s_valid = 1'b0;
    s_last = 1'b0;
    exp_err = (n < NW) || !last_ok || (CKS && cks_bad);
    wait_done(exp_err, post);
    $display("packet sel=%0d n=%0d gaps=%0d exp_err=%0d", sel, n, gaps, exp_err);
  endtask

  task automatic mem_check(input string tag);
    int bad;
    bad = 0;
    for (int nn = 0; nn < NN; nn++)
      for (int a = 0; a < NW; a++)
        if (obs_mem[nn][a] !== exp_mem[nn][a]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_wen"}, 64'(wen), 64'd0);
    chk({tag, "_wadd"}, 64'(wadd), 64'd0);
    chk({tag, "_win"}, 64'(win), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int nn = 0; nn < NN; nn++)
      for (int a = 0; a < NW; a++) begin
        exp_mem[nn][a] = 16'hA5A5;
        obs_mem[nn][a] = 16'hA5A5;
      end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Abort mid-load after 10 beats
    start_load(5);
    for (int i = 0; i < 10; i++) send_word(5, 16'h0500 + 16'(i), 1'b0, 1'b0, 1'b1);
    s_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    outputs_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    outputs_zero("after_abort");
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    $display("abort after 10 beats applied");

    // Fresh load after abort starts at address 0
    send_packet(3, 16'h0300, 16'd1, NW, 1'b1, 1'b0, 1'b0, -1, 1'b1);

    // Full continuous load into neuron 5
    send_packet(5, 16'h0000, 16'd1, NW, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    mem_check("mem_full");

    // Same packet with valid gaps into neuron 6
    send_packet(6, 16'h0000, 16'd1, NW, 1'b1, 1'b1, 1'b0, -1, 1'b1);
    mem_check("mem_gaps");

    // Preload neuron 8, then short packet ending at word 12
    send_packet(8, 16'h0100, 16'd1, NW, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    send_packet(8, 16'h0200, 16'd1, 13, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    mem_check("mem_short");

    // Missing end-of-packet marker
    send_packet(9, 16'h0900, 16'd3, NW, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    // Out-of-range select
    start_load(30);
    @(negedge clk); #1;
    chk("badsel_err", 64'(err), 64'd1);
    chk("badsel_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("badsel_err_once", 64'(err), 64'd0);
    chk("badsel_idle", 64'(busy), 64'd0);
    $display("bad select 30 applied");

    // Start while busy is ignored; then a back-to-back start
    send_packet(10, 16'h1000, 16'd1, NW, 1'b1, 1'b0, 1'b0, 5, 1'b0);
    send_packet(12, 16'h0C00, 16'd1, NW, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    mem_check("mem_busy_b2b");

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    // Thirty words of 1: good and bad checksum
    send_packet(13, 16'h0001, 16'd0, NW, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    send_packet(14, 16'h0001, 16'd0, NW, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    mem_check("mem_cks");
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side companion to the per-neuron weight memories (DATA_WIDTH-bit words, NUM_WEIGHT deep, ports wen/wadd/win).
- Accepts a start command naming one target neuron, then a valid/ready stream of NUM_WEIGHT weight words.
- Writes each word into that neuron's memory through a one-hot write-enable bus.
- Lets weights be reloaded at run time instead of being fixed at build time.

Parameters:
- NUM_WEIGHT, 30, weights per neuron memory (depth)
- NUM_NEURON, 30, neuron memories driven (width of wen bus)
- DATA_WIDTH, 16, weight word width
- ADDR_WIDTH, $clog2(NUM_WEIGHT), weight-memory address width
- SEL_WIDTH, $clog2(NUM_NEURON), neuron-select width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle load request, sampled only in IDLE
- neuron_sel  in  SEL_WIDTH  target neuron, latched with start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  DATA_WIDTH  weight word (two's complement, passed through unchanged)
- s_last  in  1  marks final word of the packet
- wen  out  NUM_NEURON  one-hot write enable to neuron memories
- wadd  out  ADDR_WIDTH  write address
- win  out  DATA_WIDTH  write data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of load
- err  out  1  one-cycle pulse, coincident with done or with a rejected start

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0; s_ready, wen, wadd, win, busy, done, err all 0.
- States: IDLE, LOAD, DONE, plus CHK when the optional feature is compiled in.
- IDLE
  - start=1 and neuron_sel<NUM_NEURON: latch sel, clear counter, go to LOAD.
  - start=1 and neuron_sel>=NUM_NEURON: err pulses next cycle, stay IDLE.
- LOAD
  - s_ready=1 combinationally.
  - Beat = s_valid & s_ready.
  - Each beat registers wen=1<<sel, wadd=cnt, win=s_data, visible the next cycle for exactly one cycle (1-cycle write latency). Otherwise wen=0; wadd/win hold.
  - cnt increments per beat.
  - Beat with cnt==NUM_WEIGHT-1: word is written; go to DONE (or CHK). If s_last=0 on this beat, the err flag is set.
  - Beat with s_last=1 and cnt<NUM_WEIGHT-1: word is written, err flag set, go to DONE (short packet; the remaining addresses keep their old contents).
  - s_valid low: no write, counter holds; there is no timeout.
- DONE: s_ready=0; done=1 for one cycle, err=1 that cycle if the flag is set; flag cleared; go to IDLE.
- start while busy is ignored.
- Counter never exceeds NUM_WEIGHT-1; wadd never wraps.
- rst_n low mid-load aborts immediately, with no done pulse. Memory contents already written are not restored.
- Back-to-back: start is accepted on the first IDLE cycle after DONE (IDLE is one cycle minimum).

Optional Feature:
- Macro: WEIGHT_LOAD_CHECKSUM_EN.
- Defined:
  - After the NUM_WEIGHT-th word, state CHK holds s_ready=1 and accepts one extra word.
  - That word must equal the modulo-2^DATA_WIDTH sum of all written words in the packet; a mismatch sets the err flag.
  - The checksum word is never written.
  - s_last is required on the checksum word, not on the last weight.
  - A short packet skips CHK.
- Undefined: no CHK state and no accumulator; the last weight goes straight to DONE.

Decomposition:
- Shared package fnn_pkg holds:
  - the loader state enum typedef (IDLE, LOAD, CHK, DONE)
  - a DATA_WIDTH default constant of 16
  - a weight_t typedef (logic [DATA_WIDTH-1:0]).
- One natural sub-module: wl_checksum_acc, a clearable modular accumulator instantiated only under WEIGHT_LOAD_CHECKSUM_EN.
- Everything else stays in a single FSM-plus-counter module.

Test Plan:
- Reset mid-LOAD after 10 beats, then release: all outputs 0, state IDLE. A fresh start with sel=3 loads from wadd 0.
- Full load, start with sel=5, 30 continuous words 0x0000..0x001D, s_last on word 29:
  - wen=0x20 for 30 cycles, wadd 0..29, win matches input
  - done pulses one cycle after the last write; err=0.
- Valid gaps, same packet with s_valid dropped every other cycle: writes occur only on beats; final memory image identical to the full-load case; done with no err.
- Protocol errors on the packet length:
  - Short packet: s_last on word 12 gives writes to wadd 0..12, then done+err; wadd 13..29 untouched.
  - Missing s_last on word 29 gives done+err.
- Bad select: start with sel=30 produces an err pulse, no busy and no wen activity. A start asserted while busy is ignored.
- With WEIGHT_LOAD_CHECKSUM_EN, 30 words of 0x0001:
  - checksum word 0x001E gives done with no err, and the checksum word is never written
  - checksum word 0x001F gives done+err.
